// File: rtl/edge_event_detector.sv
// Multi-channel synchronised, glitch-filtered edge detector with sticky event flags.
// Optional interrupt output enabled by defining EDGE_DET_IRQ_EN.
module edge_event_detector #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH-1:0]   edge_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   clr_i,
    output logic [N_CH-1:0]   level_o,
    output logic [N_CH-1:0]   pulse_o,
    output logic [N_CH-1:0]   event_o
`ifdef EDGE_DET_IRQ_EN
    ,
    input  logic [N_CH-1:0]   irq_mask_i,
    output logic              irq_o
`endif
);

    localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   level_q;
            logic                   pulse_q;
            logic                   event_q;
            logic                   s;
            logic                   rise_en;
            logic                   fall_en;

            assign s       = sync_q[SYNC_STAGES-1];
            assign rise_en = mode_i[2*c];
            assign fall_en = mode_i[2*c+1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
                    cnt_q   <= '0;
                    level_q <= RESET_LEVEL;
                    pulse_q <= 1'b0;
                    event_q <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[SYNC_STAGES-2:0], edge_i[c]};
                    pulse_q <= 1'b0;
                    // Any sample matching the accepted level restarts the stability count.
                    if (s == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        level_q <= s;
                        cnt_q   <= '0;
                        pulse_q <= s ? rise_en : fall_en;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // A pulse arriving while clear is held still sets the flag.
                    event_q <= pulse_q | (event_q & ~clr_i[c]);
                end
            end

            assign level_o[c] = level_q;
            assign pulse_o[c] = pulse_q;
            assign event_o[c] = event_q;
        end
    endgenerate

`ifdef EDGE_DET_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(event_o & irq_mask_i);
        end
    end
`else
    // No interrupt aggregation in this build.
`endif

endmodule
